// File: rtl/axis_demux.sv
// Packet-level AXI-Stream demultiplexer. Routes each packet to the port named in the first
// beat's tuser, drops and counts packets with an out-of-range destination.
module axis_demux #(
    parameter int unsigned PORTS          = 2,
    parameter int unsigned PORT_BITS      = $clog2(PORTS),
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH     = PORT_BITS,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]       s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]       s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [PORTS*DATA_WIDTH-1:0] mn_axis_tdata,
    output logic [PORTS*KEEP_WIDTH-1:0] mn_axis_tkeep,
    output logic [PORTS*USER_WIDTH-1:0] mn_axis_tuser,
    output logic [PORTS-1:0]            mn_axis_tlast,
    output logic [PORTS-1:0]            mn_axis_tvalid,
    input  logic [PORTS-1:0]            mn_axis_tready,
    output logic [DROP_CNT_WIDTH-1:0]   drop_cnt
);

    localparam int unsigned NumCodes = 1 << PORT_BITS;

    typedef enum logic [1:0] {StHead, StFwd, StDrop} state_e;

    state_e                    state_q, state_d;
    logic [PORT_BITS-1:0]      port_q, port_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      ready_q;
    logic                      out_valid_q, out_valid_d;
    logic                      skid_valid_q, skid_valid_d;

    logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;
    logic [KEEP_WIDTH-1:0] main_keep_q, skid_keep_q;
    logic [USER_WIDTH-1:0] main_user_q, skid_user_q;
    logic                  main_last_q, skid_last_q;
    logic [PORT_BITS-1:0]  main_port_q, skid_port_q;

    logic [NumCodes-1:0]  port_ok;
    logic [PORT_BITS-1:0] dest, beat_port;
    logic                 beat, fwd, drop, drain;
    logic                 load_main_in, load_main_skid, load_skid;

    assign dest = s_axis_tuser[PORT_BITS-1:0];
    assign beat = s_axis_tvalid && ready_q;

    always_comb begin
        port_ok = '0;
        for (int unsigned i = 0; i < NumCodes; i++) begin
            port_ok[i] = (i < PORTS);
        end
    end

    // Routing FSM: destination is decoded only on the head beat of a packet.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        drop_cnt_d = drop_cnt_q;
        beat_port  = port_q;
        fwd        = 1'b0;
        drop       = 1'b0;
        if (beat) begin
            unique case (state_q)
                StHead: begin
                    if (port_ok[dest]) begin
                        fwd       = 1'b1;
                        port_d    = dest;
                        beat_port = dest;
                        state_d   = s_axis_tlast ? StHead : StFwd;
                    end else begin
                        drop    = 1'b1;
                        state_d = s_axis_tlast ? StHead : StDrop;
                    end
                end
                StFwd: begin
                    fwd = 1'b1;
                    if (s_axis_tlast) state_d = StHead;
                end
                StDrop: begin
                    if (s_axis_tlast) state_d = StHead;
                end
                default: state_d = StHead;
            endcase
        end
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

    always_comb begin
        mn_axis_tvalid = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            mn_axis_tvalid[i] = out_valid_q && (main_port_q == PORT_BITS'(i));
        end
    end

    assign drain = |(mn_axis_tvalid & mn_axis_tready);

    // Skid holds a beat only while main is stalled; it always refills main first to keep order.
    always_comb begin
        out_valid_d    = out_valid_q;
        skid_valid_d   = skid_valid_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                load_main_skid = 1'b1;
                out_valid_d    = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (fwd) begin
                load_main_in = 1'b1;
                out_valid_d  = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fwd) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StHead;
            port_q       <= '0;
            drop_cnt_q   <= '0;
            ready_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            drop_cnt_q   <= drop_cnt_d;
            ready_q      <= ~skid_valid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_keep_q <= skid_keep_q;
            main_user_q <= skid_user_q;
            main_last_q <= skid_last_q;
            main_port_q <= skid_port_q;
        end else if (load_main_in) begin
            main_data_q <= s_axis_tdata;
            main_keep_q <= s_axis_tkeep;
            main_user_q <= s_axis_tuser;
            main_last_q <= s_axis_tlast;
            main_port_q <= beat_port;
        end
        if (load_skid) begin
            skid_data_q <= s_axis_tdata;
            skid_keep_q <= s_axis_tkeep;
            skid_user_q <= s_axis_tuser;
            skid_last_q <= s_axis_tlast;
            skid_port_q <= beat_port;
        end
    end

    assign s_axis_tready = ready_q;
    assign drop_cnt      = drop_cnt_q;
    assign mn_axis_tdata = {PORTS{main_data_q}};
    assign mn_axis_tkeep = {PORTS{main_keep_q}};
    assign mn_axis_tuser = {PORTS{main_user_q}};
    assign mn_axis_tlast = {PORTS{main_last_q}};

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux with 3 ports (one invalid destination code) and a 2-bit drop
// counter; each step drives inputs 1ns after an edge and checks outputs 1ns after the next.
module tb_axis_demux;

    localparam int unsigned PORTS = 3;
    localparam int unsigned PB    = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned KW    = 2;
    localparam int unsigned UW    = 2;
    localparam int unsigned CW    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DW-1:0]       s_tdata;
    logic [KW-1:0]       s_tkeep;
    logic [UW-1:0]       s_tuser;
    logic                s_tlast;
    logic                s_tvalid;
    logic                s_tready;
    logic [PORTS*DW-1:0] m_tdata;
    logic [PORTS*KW-1:0] m_tkeep;
    logic [PORTS*UW-1:0] m_tuser;
    logic [PORTS-1:0]    m_tlast;
    logic [PORTS-1:0]    m_tvalid;
    logic [PORTS-1:0]    m_tready;
    logic [CW-1:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    axis_demux #(
        .PORTS(PORTS),
        .PORT_BITS(PB),
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .USER_WIDTH(UW),
        .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .mn_axis_tdata(m_tdata),
        .mn_axis_tkeep(m_tkeep),
        .mn_axis_tuser(m_tuser),
        .mn_axis_tlast(m_tlast),
        .mn_axis_tvalid(m_tvalid),
        .mn_axis_tready(m_tready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = 2'b11;
        s_tuser  = u;
        s_tlast  = l;
    endtask

    // One accepted beat that must appear on port p right after the accepting edge.
    task automatic fwd_beat(input string tag, input logic [DW-1:0] d, input logic [UW-1:0] u,
                            input logic l, input int p);
        logic [PORTS-1:0] ev;
        ev = 3'b001 << p;
        drive(d, u, l);
        tick();
        check({tag, "_ready"}, 32'(s_tready), 32'd1);
        check({tag, "_valid"}, 32'(m_tvalid), 32'(ev));
        check({tag, "_data"}, 32'(m_tdata[p*DW +: DW]), 32'(d));
        check({tag, "_last"}, 32'(m_tlast[p]), 32'(l));
        check({tag, "_user"}, 32'(m_tuser[p*UW +: UW]), 32'(u));
    endtask

    task automatic drop_beat(input string tag, input logic [DW-1:0] d, input logic [UW-1:0] u,
                             input logic l, input logic [CW-1:0] cnt);
        drive(d, u, l);
        tick();
        check({tag, "_ready"}, 32'(s_tready), 32'd1);
        check({tag, "_valid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_cnt"}, 32'(drop_cnt), 32'(cnt));
    endtask

    task automatic idle(input string tag);
        s_tvalid = 1'b0;
        tick();
        check({tag, "_idle"}, 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 3'b111;

        // Reset state and release
        tick();
        tick();
        check("rst_ready", 32'(s_tready), 32'd0);
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", 32'(s_tready), 32'd1);

        // 4-beat packet to port 1
        fwd_beat("p1b0", 16'h10, 2'd1, 1'b0, 1);
        fwd_beat("p1b1", 16'h11, 2'd1, 1'b0, 1);
        fwd_beat("p1b2", 16'h12, 2'd1, 1'b0, 1);
        fwd_beat("p1b3", 16'h13, 2'd1, 1'b1, 1);
        idle("p1");

        // Back-to-back packets, mid-packet tuser must not reroute
        fwd_beat("b2b_a0", 16'h20, 2'd0, 1'b0, 0);
        fwd_beat("b2b_a1", 16'h21, 2'd2, 1'b0, 0);
        fwd_beat("b2b_a2", 16'h22, 2'd3, 1'b1, 0);
        fwd_beat("b2b_b0", 16'h30, 2'd1, 1'b1, 1);
        fwd_beat("b2b_c0", 16'h40, 2'd0, 1'b0, 0);
        fwd_beat("b2b_c1", 16'h41, 2'd1, 1'b1, 0);
        idle("b2b");

        // Backpressure on port 0 for 5 edges
        fwd_beat("bp0", 16'h50, 2'd0, 1'b0, 0);
        m_tready = 3'b110;
        drive(16'h51, 2'd0, 1'b0);
        tick();
        check("bp_skid_ready", 32'(s_tready), 32'd0);
        check("bp_skid_data", 32'(m_tdata[15:0]), 32'h50);
        drive(16'h52, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_ready", 32'(s_tready), 32'd0);
            check("bp_hold_valid", 32'(m_tvalid), 32'd1);
            check("bp_hold_data", 32'(m_tdata[15:0]), 32'h50);
        end
        m_tready = 3'b111;
        tick();
        check("bp_rel_ready", 32'(s_tready), 32'd1);
        check("bp_rel_valid", 32'(m_tvalid), 32'd1);
        check("bp_rel_data", 32'(m_tdata[15:0]), 32'h51);
        fwd_beat("bp2", 16'h52, 2'd0, 1'b0, 0);
        fwd_beat("bp3", 16'h53, 2'd0, 1'b0, 0);
        fwd_beat("bp4", 16'h54, 2'd0, 1'b0, 0);
        fwd_beat("bp5", 16'h55, 2'd0, 1'b1, 0);
        idle("bp");

        // Invalid destination 3: dropped at full rate, then a port-2 packet
        drop_beat("drop0", 16'h60, 2'd3, 1'b0, 2'd1);
        drop_beat("drop1", 16'h61, 2'd0, 1'b0, 2'd1);
        drop_beat("drop2", 16'h62, 2'd1, 1'b1, 2'd1);
        fwd_beat("p2b0", 16'h70, 2'd2, 1'b0, 2);
        fwd_beat("p2b1", 16'h71, 2'd2, 1'b1, 2);
        idle("p2");

        // Counter saturation from a fresh reset
        rst_n = 1'b0;
        tick();
        check("sat_rst_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        drop_beat("sat1", 16'hA1, 2'd3, 1'b1, 2'd1);
        drop_beat("sat2", 16'hA2, 2'd3, 1'b1, 2'd2);
        drop_beat("sat3", 16'hA3, 2'd3, 1'b1, 2'd3);
        drop_beat("sat4", 16'hA4, 2'd3, 1'b1, 2'd3);
        drop_beat("sat5", 16'hA5, 2'd3, 1'b1, 2'd3);
        idle("sat");

        // Reset mid-packet with both buffer stages full
        m_tready = 3'b101;
        drive(16'h80, 2'd1, 1'b0);
        tick();
        check("mid_b0_data", 32'(m_tdata[31:16]), 32'h80);
        drive(16'h81, 2'd1, 1'b0);
        tick();
        check("mid_b1_ready", 32'(s_tready), 32'd0);
        check("mid_b1_valid", 32'(m_tvalid), 32'd2);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        tick();
        check("mid_rst_valid", 32'(m_tvalid), 32'd0);
        check("mid_rst_ready", 32'(s_tready), 32'd0);
        check("mid_rst_cnt", 32'(drop_cnt), 32'd0);
        rst_n    = 1'b1;
        m_tready = 3'b111;
        tick();
        check("mid_rel_valid", 32'(m_tvalid), 32'd0);
        check("mid_rel_ready", 32'(s_tready), 32'd1);
        fwd_beat("mid_p0b0", 16'h90, 2'd0, 1'b0, 0);
        fwd_beat("mid_p0b1", 16'h91, 2'd0, 1'b1, 0);
        idle("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
